// File: rtl/timer.sv
// timer -- memory-mapped DMG timer block (DIV / TIMA / TMA / TAC at FF04-FF07).
//
// Ports:
//   clk                input  T-cycle clock
//   reset              input  asynchronous, active-high reset
//   t_cycle[1:0]       input  CPU T-cycle phase; writes commit on the edge where t_cycle==3
//   mem_addr[15:0]     input  system bus address
//   mem_enable         input  bus access enable
//   mem_write          input  bus write enable
//   mem_data_write[7:0] input write data
//   mem_data_read[7:0] output read data (combinational, 8'hFF when not selected)
//   mem_select         output address hits FF04-FF07 with mem_enable high (combinational)
//   interrupt_request  output one-clk pulse after TIMA is reloaded from TMA
module timer #(
  parameter logic [15:0] COUNTER_RESET = 16'hABCC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] mem_addr,
  input  logic        mem_enable,
  input  logic        mem_write,
  input  logic [7:0]  mem_data_write,
  output logic [7:0]  mem_data_read,
  output logic        mem_select,
  output logic        interrupt_request
);

  logic [15:0] counter;
  logic [7:0]  tima, tma;
  logic [2:0]  tac;
  logic [2:0]  reload;     // overflow countdown: 4 after overflow, reload happens when it reads 1
  logic        prev_tick;

  logic        tap, tick, fall;
  logic        wr, wr_div, wr_tima, wr_tma, wr_tac;
  logic [7:0]  tima_next, tma_next;
  logic [2:0]  reload_next;
  logic        irq_next;

  // FF04..FF07 share address bits [15:2]
  assign mem_select = mem_enable && (mem_addr[15:2] == 14'h3FC1);

  assign wr      = mem_select && mem_write && (t_cycle == 2'd3);
  assign wr_div  = wr && (mem_addr[1:0] == 2'd0);
  assign wr_tima = wr && (mem_addr[1:0] == 2'd1);
  assign wr_tma  = wr && (mem_addr[1:0] == 2'd2);
  assign wr_tac  = wr && (mem_addr[1:0] == 2'd3);

  always_comb begin
    case (tac[1:0])
      2'b00:   tap = counter[9];
      2'b01:   tap = counter[3];
      2'b10:   tap = counter[5];
      default: tap = counter[7];
    endcase
  end

  // Falling edge of the gated tap. DIV resets and TAC changes can drop the
  // tick too; those glitch increments are deliberate hardware behaviour.
  assign tick = tac[2] & tap;
  assign fall = prev_tick & ~tick;

  always_comb begin
    mem_data_read = 8'hFF;
    if (mem_select) begin
      case (mem_addr[1:0])
        2'd0:    mem_data_read = counter[15:8];
        2'd1:    mem_data_read = tima;
        2'd2:    mem_data_read = tma;
        default: mem_data_read = {5'b11111, tac};
      endcase
    end
  end

  assign tma_next = wr_tma ? mem_data_write : tma;

  always_comb begin
    tima_next   = tima;
    reload_next = reload;
    irq_next    = 1'b0;
    if (reload != 3'd0) reload_next = reload - 3'd1;
    if (reload == 3'd1) begin
      // Reload edge: TMA (including a same-edge TMA write) beats any TIMA write.
      tima_next = tma_next;
      irq_next  = 1'b1;
    end else begin
      if (fall) begin
        if (tima == 8'hFF) begin
          tima_next   = 8'h00;
          reload_next = 3'd4;
        end else begin
          tima_next = tima + 8'd1;
        end
      end
      // A CPU write wins over an increment and cancels a pending reload.
      if (wr_tima) begin
        tima_next   = mem_data_write;
        reload_next = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter           <= COUNTER_RESET;
      tima              <= 8'h00;
      tma               <= 8'h00;
      tac               <= 3'd0;
      reload            <= 3'd0;
      prev_tick         <= 1'b0;
      interrupt_request <= 1'b0;
    end else begin
      counter           <= wr_div ? 16'h0000 : counter + 16'd1;
      tima              <= tima_next;
      tma               <= tma_next;
      if (wr_tac) tac   <= mem_data_write[2:0];
      reload            <= reload_next;
      prev_tick         <= tick;
      interrupt_request <= irq_next;
    end
  end

endmodule

// File: tb/tb_timer.sv
`timescale 1ns/1ps
module tb_timer;
  localparam logic [15:0] CRST = 16'hABCC;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  t_cycle;
  logic [15:0] mem_addr;
  logic        mem_enable, mem_write;
  logic [7:0]  mem_data_write;
  logic [7:0]  mem_data_read;
  logic        mem_select, interrupt_request;

  timer #(.COUNTER_RESET(CRST)) dut (
    .clk(clk), .reset(reset), .t_cycle(t_cycle), .mem_addr(mem_addr),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_data_write(mem_data_write),
    .mem_data_read(mem_data_read), .mem_select(mem_select),
    .interrupt_request(interrupt_request)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic started = 1'b0;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Register file plus an absolute cycle stamp for the pending TMA reload.
  logic [15:0] m_cnt;
  logic [7:0]  m_tima, m_tma;
  logic [2:0]  m_tac;
  logic        m_prev, m_irq;
  int          cyc, reload_at;

  function automatic int tap_bit(input logic [1:0] s);
    return (s == 2'd0) ? 9 : 2 * int'(s) + 1;
  endfunction

  initial begin : model
    logic tk, fall, wany, wdiv, wtima, wtma, wtac;
    logic [7:0] tma_new;
    forever begin
      @(posedge clk or posedge reset);
      if (reset === 1'b1) begin
        m_cnt = CRST; m_tima = 8'h00; m_tma = 8'h00; m_tac = 3'd0;
        m_prev = 1'b0; m_irq = 1'b0; cyc = 0; reload_at = -1;
      end else begin
        cyc++;
        tk    = m_tac[2] & m_cnt[tap_bit(m_tac[1:0])];
        fall  = m_prev & ~tk;
        m_prev = tk;
        wany  = (t_cycle == 2'd3) && mem_enable && mem_write;
        wdiv  = wany && (mem_addr == 16'hFF04);
        wtima = wany && (mem_addr == 16'hFF05);
        wtma  = wany && (mem_addr == 16'hFF06);
        wtac  = wany && (mem_addr == 16'hFF07);
        tma_new = wtma ? mem_data_write : m_tma;
        m_irq = 1'b0;
        if (reload_at == cyc) begin
          m_tima = tma_new; m_irq = 1'b1; reload_at = -1;
        end else begin
          if (fall) begin
            if (m_tima == 8'hFF) begin m_tima = 8'h00; reload_at = cyc + 4; end
            else m_tima = m_tima + 8'd1;
          end
          if (wtima) begin m_tima = mem_data_write; reload_at = -1; end
        end
        m_tma = tma_new;
        if (wtac) m_tac = mem_data_write[2:0];
        m_cnt = wdiv ? 16'h0000 : m_cnt + 16'd1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic       c_sel;
  logic [7:0] c_rd;
  initial begin : compare
    forever begin
      @(negedge clk);
      if (started && reset === 1'b0) begin
        c_sel = mem_enable && (mem_addr >= 16'hFF04) && (mem_addr <= 16'hFF07);
        case (mem_addr)
          16'hFF04: c_rd = m_cnt[15:8];
          16'hFF05: c_rd = m_tima;
          16'hFF06: c_rd = m_tma;
          default:  c_rd = {5'b11111, m_tac};
        endcase
        chk1("model_sel", mem_select, c_sel);
        if (c_sel) chk8("model_rd", mem_data_read, c_rd);
        chk1("model_irq", interrupt_request, m_irq);
      end
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d, input logic [1:0] tc);
    @(posedge clk); #1;
    mem_addr = a; mem_data_write = d; mem_enable = 1'b1; mem_write = 1'b1; t_cycle = tc;
    @(posedge clk); #1;
    mem_enable = 1'b0; mem_write = 1'b0; t_cycle = 2'd0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [7:0] d, output logic s);
    @(posedge clk); #1;
    mem_addr = a; mem_enable = 1'b1; mem_write = 1'b0; t_cycle = 2'd0;
    @(negedge clk);
    d = mem_data_read; s = mem_select;
  endtask

  // Wait for TIMA to leave 'old'; n = negedges elapsed.
  task automatic watch(input logic [7:0] old, output logic [7:0] v, output int n);
    n = 0; v = old;
    @(posedge clk); #1;
    mem_addr = 16'hFF05; mem_enable = 1'b1; mem_write = 1'b0;
    while (v == old && n < 200) begin
      @(negedge clk); n++; v = mem_data_read;
    end
    if (v == old) begin
      total++; bad++;
      $display("FAIL watch_timeout: TIMA stuck at %h", old);
    end
  endtask

  task automatic wait_div1(input logic val);
    int n = 0;
    @(posedge clk); #1;
    mem_addr = 16'hFF04; mem_enable = 1'b1; mem_write = 1'b0;
    do begin @(negedge clk); n++; end while (mem_data_read[1] !== val && n < 1500);
    if (mem_data_read[1] !== val) begin
      total++; bad++;
      $display("FAIL div_wait_timeout: DIV[1] never %b", val);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : main
    logic [7:0] d, v;
    logic s;
    int n;
    reset = 1'b0; t_cycle = 2'd0; mem_addr = 16'h0000; mem_enable = 1'b0;
    mem_write = 1'b0; mem_data_write = 8'h00;
    #1 reset = 1'b1; started = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    bus_rd(16'hFF04, d, s); chk8("rst_div", d, 8'hAB); chk1("rst_sel", s, 1'b1);
    bus_rd(16'hFF07, d, s); chk8("rst_tac", d, 8'hF8);
    bus_rd(16'hFF05, d, s); chk8("rst_tima", d, 8'h00);
    bus_rd(16'hFF06, d, s); chk8("rst_tma", d, 8'h00);
    bus_rd(16'hFF08, d, s); chk8("ff08_rd", d, 8'hFF); chk1("ff08_sel", s, 1'b0);

    // overflow and reload with TAC=101
    bus_wr(16'hFF06, 8'h42, 2'd3);
    bus_wr(16'hFF06, 8'h77, 2'd1);         // wrong phase, must not commit
    bus_rd(16'hFF06, d, s); chk8("tma_phase", d, 8'h42);
    bus_wr(16'hFF05, 8'hFD, 2'd3);
    bus_wr(16'hFF07, 8'h05, 2'd3);
    watch(8'hFD, v, n); chk8("step_fe", v, 8'hFE);
    watch(8'hFE, v, n); chk8("step_ff", v, 8'hFF); chki("gap_ff", n, 16);
    watch(8'hFF, v, n); chk8("step_00", v, 8'h00); chki("gap_00", n, 16);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk8("cd_tima", mem_data_read, 8'h00); chk1("cd_irq", interrupt_request, 1'b0);
    end
    @(negedge clk);
    chk8("reload_tima", mem_data_read, 8'h42); chk1("reload_irq", interrupt_request, 1'b1);
    @(negedge clk);
    chk1("irq_one_clk", interrupt_request, 1'b0);

    // TIMA write two clks after overflow cancels the reload
    bus_wr(16'hFF05, 8'hFD, 2'd3);
    watch(8'hFD, v, n);
    watch(8'hFE, v, n);
    watch(8'hFF, v, n); chk8("ovf2_00", v, 8'h00);
    bus_wr(16'hFF05, 8'h10, 2'd3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); chk1("cancel_irq", interrupt_request, 1'b0);
    end
    bus_rd(16'hFF05, d, s); chk8("cancel_tima", d, 8'h10);

    // DIV write while counter[3]=1
    bus_wr(16'hFF05, 8'h20, 2'd3);
    watch(8'h20, v, n); chk8("inc_21", v, 8'h21);
    repeat (8) @(posedge clk);             // counter[3:0] reaches 1010 at the commit edge
    bus_wr(16'hFF04, 8'h55, 2'd3);
    bus_rd(16'hFF04, d, s); chk8("div_clr", d, 8'h00);
    bus_rd(16'hFF05, d, s); chk8("div_glitch", d, 8'h22);

    // TAC disable while counter[9]=1
    bus_wr(16'hFF07, 8'h04, 2'd3);
    wait_div1(1'b0);
    wait_div1(1'b1);
    bus_wr(16'hFF05, 8'h30, 2'd3);
    bus_wr(16'hFF07, 8'h00, 2'd3);
    bus_rd(16'hFF05, d, s); chk8("tac_glitch", d, 8'h31);
    repeat (2100) @(posedge clk);
    bus_rd(16'hFF05, d, s); chk8("tac_hold", d, 8'h31);

    // reset during the reload countdown
    bus_wr(16'hFF06, 8'h42, 2'd3);
    bus_wr(16'hFF07, 8'h05, 2'd3);
    bus_wr(16'hFF05, 8'hFF, 2'd3);
    watch(8'hFF, v, n); chk8("ovf3_00", v, 8'h00);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 chk1("async_irq", interrupt_request, 1'b0);
    chk8("async_tima", mem_data_read, 8'h00);
    mem_addr = 16'hFF04;
    #1 chk8("async_div", mem_data_read, 8'hAB);
    mem_addr = 16'hFF06;
    #1 chk8("async_tma", mem_data_read, 8'h00);
    mem_addr = 16'hFF07;
    #1 chk8("async_tac", mem_data_read, 8'hF8);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); chk1("rst_noirq", interrupt_request, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
